// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and field widths.
package pll_seq_pkg;

    localparam int unsigned StateWidth  = 3;
    localparam int unsigned RelockWidth = 8;

    typedef enum logic [StateWidth-1:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input to settle metastability.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout/retry, requires a
// stable lock window before releasing the core reset, and re-runs on lock loss or request.
// Optional build macro PLL_SEQ_STATUS_EN adds a saturating count of RUN exits on relock_count.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                   clk_74a,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   reconfig_req,
    output logic                   pll_rst,
    output logic                   core_reset_n,
    output logic                   fault,
    output logic [StateWidth-1:0]  state,
    output logic [RelockWidth-1:0] relock_count
);

    localparam int unsigned TimerMaxA  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TimerMax   = (TimerMaxA > STABLE_CYCLES) ? TimerMaxA : STABLE_CYCLES;
    localparam int unsigned TimerWidth = $clog2(TimerMax + 1);
    localparam int unsigned RetryWidth = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [TimerWidth-1:0] RstLast    = TimerWidth'(RST_CYCLES - 1);
    localparam logic [TimerWidth-1:0] LockLast   = TimerWidth'(LOCK_TIMEOUT - 1);
    localparam logic [TimerWidth-1:0] StableLast = TimerWidth'(STABLE_CYCLES - 1);
    localparam logic [RetryWidth-1:0] RetryMax   = RetryWidth'(MAX_RETRIES);

    pll_state_e            state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [RetryWidth-1:0] retries_q, retries_d;
    logic [RetryWidth-1:0] retries_inc;
    logic                  pll_rst_q;
    logic                  core_reset_n_q;
    logic                  fault_q;
    logic                  locked_s;

    sync_2ff u_lock_sync (
        .clk     (clk_74a),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    assign retries_inc = retries_q + 1'b1;

    // Next-state, timer and retry bookkeeping; every exit clears the timer so it never wraps.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retries_d = retries_q;
        case (state_q)
            StResetPll: begin
                if (reconfig_req) begin
                    timer_d = '0;
                end else if (timer_q == RstLast) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (reconfig_req) begin
                    state_d = StResetPll;
                    timer_d = '0;
                end else if (locked_s) begin
                    state_d = StStable;
                    timer_d = '0;
                end else if (timer_q == LockLast) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RetryMax) ? StFault : StResetPll;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStable: begin
                if (reconfig_req) begin
                    state_d = StResetPll;
                    timer_d = '0;
                end else if (!locked_s) begin
                    // Lock glitch restarts the wait without consuming a retry.
                    state_d = StWaitLock;
                    timer_d = '0;
                end else if (timer_q == StableLast) begin
                    state_d   = StRun;
                    timer_d   = '0;
                    retries_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRun: begin
                retries_d = '0;
                timer_d   = '0;
                if (!locked_s || reconfig_req) begin
                    state_d = StResetPll;
                end
            end
            StFault: begin
                timer_d = '0;
                if (reconfig_req) begin
                    state_d   = StResetPll;
                    retries_d = '0;
                end
            end
            default: begin
                state_d   = StResetPll;
                timer_d   = '0;
                retries_d = '0;
            end
        endcase
    end

    // State registers; outputs are decoded from the next state so they align with state.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state_q        <= StResetPll;
            timer_q        <= '0;
            retries_q      <= '0;
            pll_rst_q      <= 1'b1;
            core_reset_n_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retries_q      <= retries_d;
            pll_rst_q      <= (state_d == StResetPll) || (state_d == StFault);
            core_reset_n_q <= (state_d == StRun);
            fault_q        <= (state_d == StFault);
        end
    end

    assign state        = state_q;
    assign pll_rst      = pll_rst_q;
    assign core_reset_n = core_reset_n_q;
    assign fault        = fault_q;

`ifdef PLL_SEQ_STATUS_EN
    logic [RelockWidth-1:0] relock_q;
    logic                   run_exit;

    // Lock loss and reconfig in the same cycle are one exit, so count exits, not causes.
    assign run_exit = (state_q == StRun) && (state_d != StRun);

    // Saturating RUN-exit counter, cleared only by reset.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            relock_q <= '0;
        end else if (run_exit && (relock_q != '1)) begin
            relock_q <= relock_q + 1'b1;
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed vector table, hand-written corner
// sequences and randomized stimulus, all checked against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

    localparam int RST = 4;
    localparam int LT  = 20;
    localparam int SC  = 8;
    localparam int MR  = 2;

    logic       clk_74a = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       reconfig_req = 1'b0;
    logic       pll_rst;
    logic       core_reset_n;
    logic       fault;
    logic [2:0] state;
    logic [7:0] relock_count;

    int total = 0;
    int bad   = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .reconfig_req (reconfig_req),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .fault        (fault),
        .state        (state),
        .relock_count (relock_count)
    );

    always #5 clk_74a = ~clk_74a;

    // Reference model: phase number, edge at which the phase was entered, lock timeouts so
    // far, RUN exits so far, and a two-deep history of sampled pll_locked.
    int   m_cyc = 0;
    int   m_phase = 0;
    int   m_entered = 0;
    int   m_fails = 0;
    int   m_relocks = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    function automatic int exp_rel(input int r);
`ifdef PLL_SEQ_STATUS_EN
        return r;
`else
        return 0 * r;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic go(input int p);
        m_phase   = p;
        m_entered = m_cyc;
    endtask

    // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        logic        ls;
        int          d;
        logic [13:0] exp_v;
        @(posedge clk_74a);
        m_cyc++;
        ls = m_s2;
        if (!reset_n) begin
            go(0);
            m_fails   = 0;
            m_relocks = 0;
            m_s1      = 1'b0;
            m_s2      = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = pll_locked;
            d    = m_cyc - m_entered;
            if (reconfig_req && m_phase <= 2) begin
                go(0);
            end else begin
                case (m_phase)
                    0: if (d == RST) go(1);
                    1: begin
                        if (ls) go(2);
                        else if (d == LT) begin
                            m_fails++;
                            go((m_fails == MR) ? 4 : 0);
                        end
                    end
                    2: begin
                        if (!ls) go(1);
                        else if (d == SC) begin
                            m_fails = 0;
                            go(3);
                        end
                    end
                    3: begin
                        if (!ls || reconfig_req) begin
                            if (m_relocks < 255) m_relocks++;
                            go(0);
                        end
                    end
                    default: begin
                        if (reconfig_req) begin
                            m_fails = 0;
                            go(0);
                        end
                    end
                endcase
            end
        end
        #1;
        exp_v = {3'(m_phase), (m_phase == 0 || m_phase == 4), (m_phase == 3), (m_phase == 4),
                 8'(exp_rel(m_relocks))};
        check("model", 32'({state, pll_rst, core_reset_n, fault, relock_count}), 32'(exp_v));
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string nm);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check(nm, 32'(state), 32'(st));
    endtask

    typedef struct {
        logic       rst_n;
        logic       lock;
        logic       rcf;
        int         cycles;
        logic [2:0] st;
        logic       prst;
        logic       core;
        logic       flt;
        int         rel;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst, lock, rcf, cycles -> state, pll_rst, core_reset_n, fault, relock (macro on)
        vecs.push_back('{0, 0, 0,  3, 3'd0, 1, 0, 0, 0}); // reset values
        vecs.push_back('{1, 0, 0,  3, 3'd0, 1, 0, 0, 0}); // pll_rst cycles 0-3
        vecs.push_back('{1, 0, 0,  1, 3'd1, 0, 0, 0, 0}); // into WAIT_LOCK
        vecs.push_back('{1, 1, 0,  2, 3'd1, 0, 0, 0, 0}); // lock in flight through sync
        vecs.push_back('{1, 1, 0,  1, 3'd2, 0, 0, 0, 0}); // STABLE
        vecs.push_back('{1, 1, 0,  7, 3'd2, 0, 0, 0, 0}); // still STABLE, 9 edges after lock
        vecs.push_back('{1, 1, 0,  1, 3'd3, 0, 1, 0, 0}); // RUN 10 edges after lock sampled
        vecs.push_back('{1, 1, 0,  4, 3'd3, 0, 1, 0, 0}); // RUN holds
        vecs.push_back('{1, 0, 0,  2, 3'd3, 0, 1, 0, 0}); // lock loss still in sync
        vecs.push_back('{1, 0, 1,  1, 3'd0, 1, 0, 0, 1}); // loss + reconfig: one exit
        vecs.push_back('{1, 0, 0,  1, 3'd0, 1, 0, 0, 1});
        vecs.push_back('{1, 0, 0,  2, 3'd0, 1, 0, 0, 1});
        vecs.push_back('{1, 0, 0,  1, 3'd1, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 19, 3'd1, 0, 0, 0, 1}); // last WAIT_LOCK cycle
        vecs.push_back('{1, 0, 0,  1, 3'd0, 1, 0, 0, 1}); // first timeout -> retry
        vecs.push_back('{1, 0, 0,  3, 3'd0, 1, 0, 0, 1});
        vecs.push_back('{1, 0, 0,  1, 3'd1, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 19, 3'd1, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 0,  1, 3'd4, 1, 0, 1, 1}); // second timeout -> FAULT
        vecs.push_back('{1, 0, 0,  5, 3'd4, 1, 0, 1, 1}); // FAULT is sticky
        vecs.push_back('{1, 0, 1,  1, 3'd0, 1, 0, 0, 1}); // reconfig leaves FAULT
        vecs.push_back('{1, 0, 0,  1, 3'd0, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 0,  1, 3'd0, 1, 0, 0, 0}); // reset clears relock_count

        foreach (vecs[i]) begin
            reset_n      = vecs[i].rst_n;
            pll_locked   = vecs[i].lock;
            reconfig_req = vecs[i].rcf;
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d", i),
                  32'({state, pll_rst, core_reset_n, fault, relock_count}),
                  32'({vecs[i].st, vecs[i].prst, vecs[i].core, vecs[i].flt,
                       8'(exp_rel(vecs[i].rel))}));
        end
        reconfig_req = 1'b0;

        // Lock glitch in STABLE: back to WAIT_LOCK, then a full fresh stable window.
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        wait_state(3'd2, 40, "reach_stable");
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check("glitch_still_stable", 32'(state), 32'd2);
        tick();
        check("glitch_to_wait", 32'(state), 32'd1);
        tick();
        check("glitch_restable", 32'(state), 32'd2);
        repeat (SC - 1) tick();
        check("glitch_not_run_yet", 32'(state), 32'd2);
        tick();
        check("glitch_run", 32'({state, core_reset_n, fault}), 32'({3'd3, 1'b1, 1'b0}));

        // Repeated lock loss from RUN saturates the exit counter.
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b0;
            wait_state(3'd0, 10, "loss_exit");
            pll_locked = 1'b1;
            wait_state(3'd3, 40, "relock_run");
        end
        check("relock_sat", 32'(relock_count), 32'(exp_rel(255)));
        reset_n = 1'b0;
        tick();
        check("mid_run_reset",
              32'({state, pll_rst, core_reset_n, fault, relock_count}),
              32'({3'd0, 1'b1, 1'b0, 1'b0, 8'd0}));
        reset_n = 1'b1;

        // Randomized lock behaviour, rare reconfig and rare reset.
        for (int k = 0; k < 3000; k++) begin
            reset_n      = ($urandom_range(0, 299) != 0);
            reconfig_req = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
